// File: rtl/bot_line_follower.sv
// Rojobot line follower: steers from line/proximity sensors once per register update.
// Outputs register one clock after an upd_sysregs toggle; a stalled update stream trips FAULT.
module bot_line_follower #(
  parameter logic [2:0]        FWD_SPD      = 3'd4,
  parameter logic [2:0]        TURN_SPD     = 3'd2,
  parameter logic [7:0]        SEARCH_LIMIT = 8'd16,
  parameter int                WDOG_W       = 24,
  parameter logic [WDOG_W-1:0] WDOG_CYCLES  = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       upd_sysregs,
  input  logic [7:0] Sensors,
  output logic [7:0] MotCtl,
  output logic [2:0] nav_state,
  output logic [7:0] upd_count,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    TURN_L = 3'd2,
    TURN_R = 3'd3,
    SEARCH = 3'd4,
    STOP   = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam logic [WDOG_W-1:0] WDOG_TERM   = WDOG_CYCLES - {{(WDOG_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]        SEARCH_TERM = SEARCH_LIMIT - 8'd1;

  state_t            state;
  state_t            state_nxt;
  logic              upd_prev;
  logic              upd_evt;
  logic [7:0]        search_cnt;
  logic [7:0]        search_nxt;
  logic [WDOG_W-1:0] wdog_cnt;
  logic [WDOG_W-1:0] wdog_nxt;
  logic              wdog_term;
  logic              prox;
  logic [2:0]        line;
  logic              unused_sensors;

  assign upd_evt        = upd_sysregs != upd_prev;
  assign wdog_term      = wdog_cnt == WDOG_TERM;
  assign prox           = Sensors[4] | Sensors[3];
  assign line           = Sensors[2:0];
  assign nav_state      = state;
  assign unused_sensors = ^Sensors[7:5];

  // Line bits are active-low: a 0 means that sensor sees the black line.
  function automatic state_t line_decode(input logic [2:0] l);
    state_t s;
    case (l)
      3'b000:         s = STOP;
      3'b111:         s = SEARCH;
      3'b101, 3'b010: s = FWD;
      3'b011, 3'b001: s = TURN_L;
      default:        s = TURN_R;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] motor_byte(input state_t s);
    logic [7:0] m;
    case (s)
      FWD:     m = {FWD_SPD, 1'b1, FWD_SPD, 1'b1};
      TURN_L:  m = {TURN_SPD, 1'b1, FWD_SPD, 1'b1};
      TURN_R:  m = {FWD_SPD, 1'b1, TURN_SPD, 1'b1};
      SEARCH:  m = {TURN_SPD, 1'b0, TURN_SPD, 1'b1};
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  always_comb begin
    state_nxt  = state;
    search_nxt = search_cnt;
    wdog_nxt   = wdog_cnt;

    if (!enable || upd_evt)
      wdog_nxt = '0;
    else if (state != IDLE && !wdog_term)
      wdog_nxt = wdog_cnt + {{(WDOG_W-1){1'b0}}, 1'b1};

    if (!enable) begin
      state_nxt  = IDLE;
      search_nxt = 8'd0;
    end else if (state == FAULT) begin
      state_nxt = FAULT;
    end else if (state == state_t'(3'd7)) begin
      state_nxt = IDLE;
    end else if (wdog_term && !upd_evt && state != IDLE) begin
      state_nxt = FAULT;
    end else if (upd_evt) begin
      if (prox) begin
        state_nxt = STOP;
      end else if (line == 3'b111) begin
        if (state == SEARCH) begin
          if (search_cnt == SEARCH_TERM)
            state_nxt = FAULT;
          else
            search_nxt = search_cnt + 8'd1;
        end else begin
          state_nxt  = SEARCH;
          search_nxt = 8'd1;
        end
      end else begin
        state_nxt = line_decode(line);
      end
    end

    if (state_nxt != SEARCH)
      search_nxt = 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      upd_prev   <= 1'b0;
      search_cnt <= 8'd0;
      wdog_cnt   <= '0;
      MotCtl     <= 8'h00;
      upd_count  <= 8'd0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      upd_prev   <= upd_sysregs;
      search_cnt <= search_nxt;
      wdog_cnt   <= wdog_nxt;
      MotCtl     <= motor_byte(state_nxt);
      fault      <= state_nxt == FAULT;
      if (upd_evt)
        upd_count <= upd_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_bot_line_follower.sv
// Directed bench for bot_line_follower with a short search limit and watchdog.
module tb_bot_line_follower;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       upd;
  logic [7:0] sensors;
  logic [7:0] mot;
  logic [2:0] nav;
  logic [7:0] cnt;
  logic       flt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  bot_line_follower #(
    .FWD_SPD     (3'd4),
    .TURN_SPD    (3'd2),
    .SEARCH_LIMIT(8'd4),
    .WDOG_W      (24),
    .WDOG_CYCLES (24'd100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .upd_sysregs(upd),
    .Sensors    (sensors),
    .MotCtl     (mot),
    .nav_state  (nav),
    .upd_count  (cnt),
    .fault      (flt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [2:0] n, input logic [7:0] m);
    chk({tag, ".nav"}, 32'(nav), 32'(n));
    chk({tag, ".mot"}, 32'(mot), 32'(m));
  endtask

  task automatic tog(input logic [7:0] s);
    @(negedge clk);
    sensors = s;
    upd     = ~upd;
    exp_cnt = exp_cnt + 8'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    enable  = 1'b0;
    upd     = 1'b0;
    sensors = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    st("reset", 3'd0, 8'h00);
    chk("reset.cnt", 32'(cnt), 32'd0);
    chk("reset.fault", 32'(flt), 32'd0);

    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    st("idle_no_evt", 3'd0, 8'h00);

    tog(8'h05); st("fwd101", 3'd1, 8'h99);
    chk("cnt_first", 32'(cnt), 32'(exp_cnt));
    tog(8'h03); st("turnl011", 3'd2, 8'h59);
    tog(8'h06); st("turnr110", 3'd3, 8'h95);
    tog(8'h05); st("fwd_again", 3'd1, 8'h99);
    tog(8'h15); st("prox_left", 3'd5, 8'h00);
    tog(8'h0D); st("prox_right", 3'd5, 8'h00);
    tog(8'h05); st("stop_exit", 3'd1, 8'h99);
    tog(8'h00); st("line000", 3'd5, 8'h00);
    tog(8'h02); st("fwd010", 3'd1, 8'h99);
    tog(8'h04); st("turnr100", 3'd3, 8'h95);
    tog(8'h01); st("turnl001", 3'd2, 8'h59);
    chk("cnt_mid", 32'(cnt), 32'(exp_cnt));

    tog(8'h07); st("search1", 3'd4, 8'h45);
    tog(8'h07); st("search2", 3'd4, 8'h45);
    tog(8'h05); st("search_leave", 3'd1, 8'h99);
    tog(8'h07); st("search_re1", 3'd4, 8'h45);
    tog(8'h07); st("search_re2", 3'd4, 8'h45);
    tog(8'h07); st("search_re3", 3'd4, 8'h45);
    chk("search_re3.fault", 32'(flt), 32'd0);
    tog(8'h07); st("search_fault", 3'd6, 8'h00);
    chk("search_fault.fault", 32'(flt), 32'd1);
    tog(8'h05); st("fault_sticky", 3'd6, 8'h00);
    chk("fault_sticky.fault", 32'(flt), 32'd1);
    chk("cnt_fault", 32'(cnt), 32'(exp_cnt));

    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    st("fault_clear", 3'd0, 8'h00);
    chk("fault_clear.fault", 32'(flt), 32'd0);

    @(negedge clk);
    enable = 1'b1;
    tog(8'h05); st("wd_fwd", 3'd1, 8'h99);
    repeat (99) @(posedge clk);
    #1;
    st("wd_99", 3'd1, 8'h99);
    @(posedge clk);
    #1;
    st("wd_100", 3'd6, 8'h00);
    chk("wd_100.fault", 32'(flt), 32'd1);

    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    st("wd_idle", 3'd0, 8'h00);
    @(negedge clk);
    enable = 1'b1;
    tog(8'h05); st("wd2_fwd", 3'd1, 8'h99);
    repeat (98) @(posedge clk);
    tog(8'h05); st("wd2_kick99", 3'd1, 8'h99);
    @(posedge clk);
    #1;
    st("wd2_100", 3'd1, 8'h99);
    repeat (98) @(posedge clk);
    #1;
    st("wd2_199", 3'd1, 8'h99);
    @(posedge clk);
    #1;
    st("wd2_200", 3'd6, 8'h00);

    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    enable = 1'b1;
    tog(8'h05); st("en_fwd", 3'd1, 8'h99);
    @(negedge clk);
    enable  = 1'b0;
    sensors = 8'h06;
    upd     = ~upd;
    exp_cnt = exp_cnt + 8'd1;
    @(posedge clk);
    #1;
    st("en_drop_evt", 3'd0, 8'h00);
    chk("en_drop_cnt", 32'(cnt), 32'(exp_cnt));

    @(negedge clk);
    enable = 1'b1;
    tog(8'h05); st("rst_pre", 3'd1, 8'h99);
    #2;
    reset   = 1'b0;
    upd     = 1'b1;
    sensors = 8'h05;
    #1;
    st("rst_async", 3'd0, 8'h00);
    chk("rst_async.cnt", 32'(cnt), 32'd0);
    chk("rst_async.fault", 32'(flt), 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    exp_cnt = 8'd1;
    @(posedge clk);
    #1;
    st("rst_release_evt", 3'd1, 8'h99);
    chk("rst_release_cnt", 32'(cnt), 32'(exp_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
